// File: rtl/uart_tx_pkg.sv
// uart_tx_pkg
// Shared definitions for the UART transmit controller: frame FSM state
// encoding, parity type constants and the parity helper.
package uart_tx_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP1  = 3'd4,
    STOP2  = 3'd5
  } tx_state_e;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  // Widest legal data word; narrower words are zero-extended, which does not
  // change their XOR reduction.
  localparam int MAX_DATA_W = 9;

  // Parity bit for a data word: even parity makes the total count of ones
  // even, odd parity makes it odd.
  function automatic logic parity_bit(input logic [MAX_DATA_W-1:0] data,
                                      input logic                  typ);
    parity_bit = (^data) ^ (typ == PAR_ODD);
  endfunction

endpackage

// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer
// Shift register and bit counter for the data phase of a UART frame.
// Ports:
//   CLK, RST   clock, asynchronous active-low reset
//   load_i     load data_i into the shift register and clear the counter
//   shift_i    shift right by one and advance the counter
//   data_i     word to serialize
//   lsb_o      current LSB (bit on the line in this data slot)
//   next_o     bit that becomes the LSB after the next shift
//   done_o     counter has reached the last data bit
module uart_tx_serializer
  import uart_tx_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_W      = $clog2(DATA_WIDTH)
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  load_i,
  input  logic                  shift_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic                  lsb_o,
  output logic                  next_o,
  output logic                  done_o
);

  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]      cnt_q,   cnt_d;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      shift_q <= '0;
      cnt_q   <= '0;
    end else begin
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
    end
  end

  assign done_o = (cnt_q == CNT_W'(DATA_WIDTH - 1));
  assign lsb_o  = shift_q[0];
  assign next_o = shift_q[1];

  always_comb begin
    shift_d = shift_q;
    cnt_d   = cnt_q;
    if (load_i) begin
      shift_d = data_i;
      cnt_d   = '0;
    end else if (shift_i) begin
      shift_d = {1'b0, shift_q[DATA_WIDTH-1:1]};
      // Saturate on the last bit so a stray shift can never wrap the count.
      if (!done_o) cnt_d = cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/uart_tx_ctrl.sv
// uart_tx_ctrl
// UART transmit controller: one-entry holding buffer, frame FSM, parity
// generation and serializer. Frames are START, DATA_WIDTH data bits (LSB
// first), optional parity, one or two stop bits; the FSM advances only on
// Bit_Tick and chains frames with no idle gap when the buffer is full.
// Ports:
//   CLK, RST     clock, asynchronous active-low reset
//   P_DATA       parallel data, captured on Data_Valid && Data_Ready
//   Data_Valid   producer offers P_DATA and config
//   Data_Ready   holding buffer empty
//   Par_En       parity bit enable (captured with P_DATA)
//   Par_Typ      0 even, 1 odd (captured with P_DATA)
//   Stop2        two stop bits (captured with P_DATA)
//   Bit_Tick     one-cycle strobe per bit period
//   TX_OUT       registered serial line, idle high
//   Busy         registered, high while a frame is on the line
module uart_tx_ctrl
  import uart_tx_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_W      = $clog2(DATA_WIDTH)
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  Data_Valid,
  output logic                  Data_Ready,
  input  logic                  Par_En,
  input  logic                  Par_Typ,
  input  logic                  Stop2,
  input  logic                  Bit_Tick,
  output logic                  TX_OUT,
  output logic                  Busy
);

  tx_state_e state_q, state_d;
  logic      tx_q, tx_d;
  logic      busy_q, busy_d;

  // Holding buffer
  logic                  buf_full_q;
  logic [DATA_WIDTH-1:0] buf_data_q;
  logic                  buf_pe_q, buf_pt_q, buf_s2_q;

  // Per-frame configuration, latched when the buffer moves out
  logic par_en_q, stop2_q, par_bit_q;

  logic capture, move_out, ser_load, ser_shift;
  logic ser_lsb, ser_next, ser_done;

  assign Data_Ready = !buf_full_q;
  assign capture    = Data_Valid && !buf_full_q;
  assign TX_OUT     = tx_q;
  assign Busy       = busy_q;

  uart_tx_serializer #(
    .DATA_WIDTH (DATA_WIDTH),
    .CNT_W      (CNT_W)
  ) u_ser (
    .CLK     (CLK),
    .RST     (RST),
    .load_i  (ser_load),
    .shift_i (ser_shift),
    .data_i  (buf_data_q),
    .lsb_o   (ser_lsb),
    .next_o  (ser_next),
    .done_o  (ser_done)
  );

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q    <= IDLE;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      buf_full_q <= 1'b0;
      buf_data_q <= '0;
      buf_pe_q   <= 1'b0;
      buf_pt_q   <= 1'b0;
      buf_s2_q   <= 1'b0;
      par_en_q   <= 1'b0;
      stop2_q    <= 1'b0;
      par_bit_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      // capture needs the buffer empty and move_out needs it full, so the
      // two never fire on the same edge.
      if (capture) begin
        buf_full_q <= 1'b1;
        buf_data_q <= P_DATA;
        buf_pe_q   <= Par_En;
        buf_pt_q   <= Par_Typ;
        buf_s2_q   <= Stop2;
      end else if (move_out) begin
        buf_full_q <= 1'b0;
      end
      if (move_out) begin
        par_en_q  <= buf_pe_q;
        stop2_q   <= buf_s2_q;
        // Parity comes from the captured word; the shift register is
        // consumed during DATA so it cannot be used later.
        par_bit_q <= parity_bit(MAX_DATA_W'(buf_data_q), buf_pt_q);
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    tx_d      = tx_q;
    busy_d    = busy_q;
    move_out  = 1'b0;
    ser_load  = 1'b0;
    ser_shift = 1'b0;
    if (Bit_Tick) begin
      case (state_q)
        IDLE: begin
          tx_d = 1'b1;
          if (buf_full_q) begin
            state_d  = START;
            tx_d     = 1'b0;
            move_out = 1'b1;
            ser_load = 1'b1;
          end
        end
        START: begin
          state_d = DATA;
          tx_d    = ser_lsb;
        end
        DATA: begin
          if (ser_done) begin
            if (par_en_q) begin
              state_d = PARITY;
              tx_d    = par_bit_q;
            end else begin
              state_d = STOP1;
              tx_d    = 1'b1;
            end
          end else begin
            ser_shift = 1'b1;
            tx_d      = ser_next;
          end
        end
        PARITY: begin
          state_d = STOP1;
          tx_d    = 1'b1;
        end
        STOP1, STOP2: begin
          tx_d = 1'b1;
          if (state_q == STOP1 && stop2_q) begin
            state_d = STOP2;
          end else if (buf_full_q) begin
            // Chain straight into the next frame without an idle bit.
            state_d  = START;
            tx_d     = 1'b0;
            move_out = 1'b1;
            ser_load = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
        default: begin
          state_d = IDLE;
          tx_d    = 1'b1;
        end
      endcase
      busy_d = (state_d != IDLE);
    end
  end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
module tb_uart_tx_ctrl;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic [7:0] P_DATA = '0;
  logic       Data_Valid = 1'b0;
  logic       Data_Ready;
  logic       Par_En = 1'b0;
  logic       Par_Typ = 1'b0;
  logic       Stop2 = 1'b0;
  logic       Bit_Tick = 1'b1;
  logic       TX_OUT;
  logic       Busy;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 CLK = ~CLK;

  uart_tx_ctrl #(.DATA_WIDTH(8)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .P_DATA     (P_DATA),
    .Data_Valid (Data_Valid),
    .Data_Ready (Data_Ready),
    .Par_En     (Par_En),
    .Par_Typ    (Par_Typ),
    .Stop2      (Stop2),
    .Bit_Tick   (Bit_Tick),
    .TX_OUT     (TX_OUT),
    .Busy       (Busy)
  );

  // Offer one word for one cycle; caller is 1 time unit past an edge with
  // Data_Ready high. Returns 1 time unit past the capture edge.
  task automatic offer(input logic [7:0] d, input logic pe, input logic pt,
                       input logic s2);
    P_DATA = d; Par_En = pe; Par_Typ = pt; Stop2 = s2; Data_Valid = 1'b1;
    @(posedge CLK); #1;
    Data_Valid = 1'b0;
  endtask

  // Sample TX_OUT/Busy after each of the next n edges; bit i = edge i.
  task automatic grab(input int n, output logic [31:0] txv,
                      output logic [31:0] bv);
    txv = '0; bv = '0;
    for (int i = 0; i < n; i++) begin
      @(posedge CLK); #1;
      txv[i] = TX_OUT;
      bv[i]  = Busy;
    end
  endtask

  task automatic test_reset;
    n_checks++;
    if (TX_OUT !== 1'b1) $display("FAIL reset_tx: got %b expected 1", TX_OUT);
    else n_pass++;
    n_checks++;
    if (Busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", Busy);
    else n_pass++;
    n_checks++;
    if (Data_Ready !== 1'b1) $display("FAIL reset_ready: got %b expected 1", Data_Ready);
    else n_pass++;
  endtask

  task automatic test_basic_frame;
    logic [31:0] txv, bv;
    offer(8'hA5, 1'b1, 1'b0, 1'b0);
    grab(11, txv, bv);
    n_checks++;
    if (txv[10:0] !== 11'h54A) $display("FAIL a5_tx: got %h expected %h", txv[10:0], 11'h54A);
    else n_pass++;
    n_checks++;
    if (bv[10:0] !== 11'h7FF) $display("FAIL a5_busy: got %h expected %h", bv[10:0], 11'h7FF);
    else n_pass++;
    grab(1, txv, bv);
    n_checks++;
    if (txv[0] !== 1'b1 || bv[0] !== 1'b0)
      $display("FAIL a5_idle: got tx=%b busy=%b expected tx=1 busy=0", txv[0], bv[0]);
    else n_pass++;
  endtask

  task automatic test_parity;
    logic [31:0] txv, bv;
    offer(8'h01, 1'b1, 1'b1, 1'b0);
    grab(11, txv, bv);
    n_checks++;
    if (txv[10:0] !== 11'h402) $display("FAIL par_odd: got %h expected %h", txv[10:0], 11'h402);
    else n_pass++;
    grab(1, txv, bv);
    offer(8'h01, 1'b1, 1'b0, 1'b0);
    grab(11, txv, bv);
    n_checks++;
    if (txv[10:0] !== 11'h602) $display("FAIL par_even: got %h expected %h", txv[10:0], 11'h602);
    else n_pass++;
    grab(1, txv, bv);
  endtask

  task automatic test_stop2;
    logic [31:0] txv, bv;
    offer(8'h00, 1'b0, 1'b0, 1'b1);
    grab(11, txv, bv);
    n_checks++;
    if (txv[10:0] !== 11'h600) $display("FAIL stop2_tx: got %h expected %h", txv[10:0], 11'h600);
    else n_pass++;
    n_checks++;
    if (bv[10:0] !== 11'h7FF) $display("FAIL stop2_busy: got %h expected %h", bv[10:0], 11'h7FF);
    else n_pass++;
    grab(1, txv, bv);
    n_checks++;
    if (txv[0] !== 1'b1 || bv[0] !== 1'b0)
      $display("FAIL stop2_idle: got tx=%b busy=%b expected tx=1 busy=0", txv[0], bv[0]);
    else n_pass++;
  endtask

  task automatic test_back_to_back;
    logic [19:0] txv, bv, rv;
    offer(8'h3C, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      @(posedge CLK); #1;
      txv[i] = TX_OUT;
      bv[i]  = Busy;
      rv[i]  = Data_Ready;
      if (i == 1) begin
        P_DATA = 8'hC3; Par_En = 1'b0; Par_Typ = 1'b0; Stop2 = 1'b0;
        Data_Valid = 1'b1;
      end else begin
        Data_Valid = 1'b0;
      end
    end
    n_checks++;
    if (txv !== 20'hE1A78) $display("FAIL b2b_tx: got %h expected %h", txv, 20'hE1A78);
    else n_pass++;
    n_checks++;
    if (bv !== 20'hFFFFF) $display("FAIL b2b_busy: got %h expected %h", bv, 20'hFFFFF);
    else n_pass++;
    n_checks++;
    if (rv !== 20'hFFC03) $display("FAIL b2b_ready: got %h expected %h", rv, 20'hFFC03);
    else n_pass++;
    @(posedge CLK); #1;
    n_checks++;
    if (TX_OUT !== 1'b1 || Busy !== 1'b0)
      $display("FAIL b2b_idle: got tx=%b busy=%b expected tx=1 busy=0", TX_OUT, Busy);
    else n_pass++;
  endtask

  task automatic test_tick_gating;
    logic [11:0] tx_per, busy_per;
    int tx_bad, busy_bad, first_busy;
    tx_per = 12'hC3D; busy_per = 12'h7FE;
    tx_bad = 0; busy_bad = 0; first_busy = -1;
    // Valid offered in a cycle whose edge also carries a tick.
    Bit_Tick = 1'b1;
    P_DATA = 8'h0F; Par_En = 1'b0; Par_Typ = 1'b0; Stop2 = 1'b0; Data_Valid = 1'b1;
    for (int c = 0; c < 48; c++) begin
      @(posedge CLK); #1;
      Data_Valid = 1'b0;
      if (TX_OUT !== tx_per[c/4]) tx_bad++;
      if (Busy !== busy_per[c/4]) busy_bad++;
      if (Busy === 1'b1 && first_busy < 0) first_busy = c;
      Bit_Tick = ((c + 1) % 4 == 0);
    end
    Bit_Tick = 1'b1;
    n_checks++;
    if (first_busy !== 4) $display("FAIL tick_start: got edge %0d expected edge 4", first_busy);
    else n_pass++;
    n_checks++;
    if (tx_bad !== 0) $display("FAIL tick_tx: got %0d bad cycles expected 0", tx_bad);
    else n_pass++;
    n_checks++;
    if (busy_bad !== 0) $display("FAIL tick_busy: got %0d bad cycles expected 0", busy_bad);
    else n_pass++;
  endtask

  task automatic test_async_reset;
    int bad;
    offer(8'h00, 1'b1, 1'b0, 1'b0);
    @(posedge CLK); #1;                     // START entered, buffer empty
    offer(8'h00, 1'b1, 1'b0, 1'b0);         // capture on the edge entering DATA
    n_checks++;
    if (TX_OUT !== 1'b0 || Busy !== 1'b1 || Data_Ready !== 1'b0)
      $display("FAIL rst_pre: got tx=%b busy=%b rdy=%b expected tx=0 busy=1 rdy=0",
               TX_OUT, Busy, Data_Ready);
    else n_pass++;
    #2 RST = 1'b0;
    #1;
    n_checks++;
    if (TX_OUT !== 1'b1) $display("FAIL rst_tx: got %b expected 1", TX_OUT);
    else n_pass++;
    n_checks++;
    if (Busy !== 1'b0) $display("FAIL rst_busy: got %b expected 0", Busy);
    else n_pass++;
    n_checks++;
    if (Data_Ready !== 1'b1) $display("FAIL rst_ready: got %b expected 1", Data_Ready);
    else n_pass++;
    @(posedge CLK); #3;
    RST = 1'b1;
    bad = 0;
    for (int i = 0; i < 15; i++) begin
      @(posedge CLK); #1;
      if (TX_OUT !== 1'b1 || Busy !== 1'b0 || Data_Ready !== 1'b1) bad++;
    end
    n_checks++;
    if (bad !== 0) $display("FAIL rst_residual: got %0d bad cycles expected 0", bad);
    else n_pass++;
  endtask

  initial begin
    repeat (2) @(posedge CLK);
    #1;
    test_reset();
    RST = 1'b1;
    @(posedge CLK); #1;
    test_basic_frame();
    test_parity();
    test_stop2();
    test_back_to_back();
    test_tick_gating();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_tx_ctrl.md
Name: uart_tx_ctrl

Overview:
Parametrised UART transmit controller: frame FSM, serializer, parity generator and a one-entry holding buffer in one block.
Generalises the team's fixed 8-bit TX FSM:
- configurable data width
- even/odd parity
- 1 or 2 stop bits
- baud-tick gating
- back-to-back frames with no idle gap

Sits between the system-side data producer and the TX pin.

Parameters:
DATA_WIDTH, 8, data bits per frame; legal range 5..9.
CNT_W, $clog2(DATA_WIDTH), bit-counter width (derived; do not override).

Ports:
CLK  in  1  system clock
RST  in  1  asynchronous, active-low reset
P_DATA  in  DATA_WIDTH  parallel data; sampled on acceptance
Data_Valid  in  1  producer has data; transfer when Data_Valid && Data_Ready
Data_Ready  out  1  holding buffer empty
Par_En  in  1  parity bit enable; sampled with P_DATA
Par_Typ  in  1  0 = even, 1 = odd; sampled with P_DATA
Stop2  in  1  1 = two stop bits; sampled with P_DATA
Bit_Tick  in  1  one-cycle strobe per bit period; FSM advances only when high
TX_OUT  out  1  serial line, registered, idle high
Busy  out  1  registered, high while a frame is on the line

Behaviour:
- Reset (async, RST=0), takes effect immediately:
  - state=IDLE, TX_OUT=1, Busy=0, Data_Ready=1
  - holding buffer and shift register cleared
  - any frame in progress is aborted
- Holding buffer:
  - On Data_Valid && Data_Ready: capture P_DATA, Par_En, Par_Typ and Stop2; the buffer goes full next cycle, Data_Ready=0.
  - Data_Valid while Data_Ready=0 is ignored; the producer holds its data.
  - Capture and move-out never coincide, because move-out requires the buffer full.
- States:
  - IDLE, START, DATA, PARITY, STOP1, STOP2; 3-bit encoding.
  - All transitions occur only on edges where Bit_Tick=1; without a tick the state holds.
- Transitions, evaluated when Bit_Tick=1:
  - IDLE: buffer full -> START. Move the buffer into the shift register and config latches; buffer empties, Data_Ready=1 next cycle.
  - START -> DATA; bit counter=0.
  - DATA: counter==DATA_WIDTH-1 -> PARITY if Par_En, else STOP1. Otherwise shift right, counter+1.
  - PARITY -> STOP1.
  - STOP1: Stop2 -> STOP2. Otherwise: buffer full -> START (with move-out), else IDLE.
  - STOP2: buffer full -> START (with move-out), else IDLE.
- TX_OUT:
  - Registered and updated on the same edge as the state; it is the value of the state being entered.
  - Values per state:
    - IDLE 1
    - START 0
    - DATA shift[0] (LSB first)
    - PARITY ^data ^ Par_Typ
    - STOP1/STOP2 1
  - Parity is computed from the captured word, not live P_DATA.
- Busy:
  - Registered, same edge as TX_OUT.
  - 1 in every state except IDLE; stays 1 across back-to-back frames.
- Latency:
  - Acceptance in cycle t: START is entered on the first Bit_Tick at cycle >= t+1.
  - A tick coinciding with acceptance does not start the frame.
- Frame length in bit periods: 1 + DATA_WIDTH + Par_En + 1 + Stop2.
- Config inputs changed mid-frame have no effect on the current frame.
- Bit counter saturates; no wrap within a frame.

Decomposition:
- Package uart_tx_pkg:
  - state encoding constants (IDLE=0, START=1, DATA=2, PARITY=3, STOP1=4, STOP2=5)
  - parity type constants PAR_EVEN=0, PAR_ODD=1
- Sub-module uart_tx_serializer (DATA_WIDTH):
  - shift register, bit counter and done flag
  - load/shift enables driven by the FSM
- FSM, holding buffer and parity stay in uart_tx_ctrl.

Test Plan:
- DATA_WIDTH=8, Bit_Tick=1, 0xA5, Par_En=1, Par_Typ=0, Stop2=0 -> TX_OUT = 0,1,0,1,0,0,1,0,1,0,1 (11 cycles); Busy high exactly those 11 cycles.
- 0x01, Par_En=1, Par_Typ=1 -> parity bit 0; repeat with Par_Typ=0 -> parity bit 1.
- 0x00, Par_En=0, Stop2=1 -> 0, eight 0s, 1, 1; then IDLE, TX_OUT=1, Busy=0.
- 0x3C then 0xC3 offered while the first is in DATA -> Data_Ready drops and rises once. Second START immediately follows the first STOP1, with no idle bit; Busy never drops.
- Bit_Tick every 4 cycles -> each bit lasts exactly 4 cycles. Valid accepted on a tick cycle -> START on the next tick, not the same one.
- RST=0 mid-DATA with the buffer full -> same cycle: TX_OUT=1, Busy=0, Data_Ready=1. After release, no residual frame is sent.
